// File: rtl/run_detect_sched.sv
// -----------------------------------------------------------------------------
// run_detect_sched
//
// Several serial channels share one run-of-ones detector. A round-robin
// arbiter grants one requesting channel per cycle. The granted channel's bit
// is consumed and updates that channel's saturating run counter. A channel
// is "detected" while its counter sits at THRESH.
//
// Parameters
//   NCH    : number of requesting channels (2..8)
//   THRESH : run length of consecutive 1s at which det asserts (1..15)
//
// Ports
//   clk       : single clock, rising-edge active
//   reset     : synchronous, active-high reset
//   req       : per-channel request; the channel presents bit_in
//   bit_in    : per-channel serial data bit, meaningful while req is high
//   clr       : per-channel clear of the run counter (next edge)
//   gnt       : one-hot combinational grant
//   det       : registered per-channel detect level (counter == THRESH)
//   det_pulse : registered one-cycle pulse on each rising edge of det
//
// Handshake: a channel holds req high with its bit on bit_in. The bit is
// consumed on the rising edge that ends a cycle in which req[k] & gnt[k] is
// high. gnt is a pure function of req and the round-robin pointer, so it never
// depends on bit_in or clr. A channel that is not granted simply keeps
// presenting its bit.
// -----------------------------------------------------------------------------
module run_detect_sched #(
    parameter int NCH    = 4,
    parameter int THRESH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] bit_in,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] gnt,
    output logic [NCH-1:0] det,
    output logic [NCH-1:0] det_pulse
);

    localparam int         PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0] TH = 4'(THRESH);

    logic [PW-1:0]  ptr_q;
    logic [PW-1:0]  ptr_d;
    logic [PW-1:0]  ptr_eff;
    logic [3:0]     cnt_q [NCH];
    logic [3:0]     cnt_d [NCH];
    logic [NCH-1:0] det_d;

    // ------------------------------------------------------------------
    // Round-robin grant: first requester at or after ptr, wrapping.
    // While reset is high the search starts at channel 0. This keeps gnt
    // well defined even though nothing is consumed in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        ptr_eff = reset ? '0 : ptr_q;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr_eff) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = (idx == NCH - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel counter update. clr has priority over a consumed bit.
    // A bit that is cleared still counts as consumed, so the pointer has
    // already moved past this channel above.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr[k]) begin
                cnt_d[k] = 4'd0;
            end else if (gnt[k]) begin
                if (!bit_in[k]) begin
                    cnt_d[k] = 4'd0;
                end else if (cnt_q[k] >= TH) begin
                    cnt_d[k] = TH;
                end else begin
                    cnt_d[k] = cnt_q[k] + 4'd1;
                end
            end
            det_d[k] = (cnt_d[k] == TH);
        end
    end

    // ------------------------------------------------------------------
    // State registers. det is registered alongside the counters from the
    // same next-state value. So det always equals (cnt_q == THRESH). That
    // makes it a Moore decode of the counter, visible the cycle after the
    // consuming grant. det_pulse compares the new level against the old
    // one, so a channel held at saturation does not pulse again.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            det       <= '0;
            det_pulse <= '0;
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= 4'd0;
            end
        end else begin
            ptr_q     <= ptr_d;
            det       <= det_d;
            det_pulse <= det_d & ~det;
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_run_detect_sched.sv
// -----------------------------------------------------------------------------
// tb_run_detect_sched
//
// Directed bench for run_detect_sched with NCH=4, THRESH=2. Inputs are driven
// on the falling edge. gnt is sampled 1 time unit later. det and det_pulse are
// sampled on the following falling edge, after the consuming rising edge.
// -----------------------------------------------------------------------------
module tb_run_detect_sched;

    localparam int NCH    = 4;
    localparam int THRESH = 2;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] req;
    logic [NCH-1:0] bit_in;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] gnt;
    logic [NCH-1:0] det;
    logic [NCH-1:0] det_pulse;

    int checks   = 0;
    int failures = 0;

    logic [NCH-1:0] exp_q[$];

    run_detect_sched #(
        .NCH    (NCH),
        .THRESH (THRESH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_in    (bit_in),
        .clr       (clr),
        .gnt       (gnt),
        .det       (det),
        .det_pulse (det_pulse)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One cycle: drive inputs, check gnt, then check the registered outputs
    // after the edge.
    task automatic step(input string tag,
                        input logic [NCH-1:0] r, input logic [NCH-1:0] b,
                        input logic [NCH-1:0] c, input logic [NCH-1:0] eg,
                        input logic [NCH-1:0] ed, input logic [NCH-1:0] ep);
        req    = r;
        bit_in = b;
        clr    = c;
        #1;
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        @(posedge clk);
        @(negedge clk);
        check({tag, ".det"}, 32'(det), 32'(ed));
        check({tag, ".pulse"}, 32'(det_pulse), 32'(ep));
    endtask

    // One reset cycle with requests and 1-bits present. These bits must not
    // be consumed, and gnt must search from channel 0.
    task automatic do_reset(input string tag, input logic [NCH-1:0] r, input logic [NCH-1:0] eg);
        reset  = 1'b1;
        req    = r;
        bit_in = '1;
        clr    = '0;
        #1;
        check({tag, ".rst_gnt"}, 32'(gnt), 32'(eg));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check({tag, ".rst_det"}, 32'(det), 32'd0);
        check({tag, ".rst_pulse"}, 32'(det_pulse), 32'd0);
    endtask

    // Saturation table for 8 cycles of req=1111, bit=1111 starting at ptr=2.
    logic [NCH-1:0] sat_gnt [8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010,
                                    4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [NCH-1:0] sat_det [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                    4'b0100, 4'b1100, 4'b1101, 4'b1111};
    logic [NCH-1:0] sat_pls [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                    4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [NCH-1:0] eg;
        reset  = 1'b1;
        req    = '0;
        bit_in = '0;
        clr    = '0;
        repeat (2) @(negedge clk);

        // Reset state; gnt during reset searches from channel 0.
        do_reset("init", 4'b0110, 4'b0010);
        step("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Single channel run of three 1s.
        step("run1", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step("run2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        step("run3", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

        // Reset mid-saturation brings ptr back to 0 and drops det.
        do_reset("rst2", 4'b0000, 4'b0000);

        // Full request: strict rotation with no skips.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(NCH'(1) << (i % NCH));
        end
        for (int i = 0; i < 8; i++) begin
            eg = exp_q.pop_front();
            step($sformatf("rr%0d", i), 4'b1111, 4'b0000, 4'b0000, eg, 4'b0000, 4'b0000);
        end

        // Sparse requests 1010 from ptr=0.
        step("sp1", 4'b1010, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        step("sp2", 4'b1010, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        step("sp3", 4'b1010, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        // cnt1=2, cnt3=1, ptr=2

        // A single 0 drops det, then 1,1 re-arms the pulse.
        step("drop", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        step("re1", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        step("re2", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        step("re3", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        // ptr=2

        // clr colliding with a grant: clr wins, ptr still advances.
        step("c2a", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0000);
        step("c2b", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0000);
        step("c2p", 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000);
        // clr without grant; gnt is unaffected by clr.
        step("c1", 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        step("call", 4'b0001, 4'b0001, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
        step("cptr", 4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        // ptr=2, all counters 0

        // Saturate every channel.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("sat%0d", i), 4'b1111, 4'b1111, 4'b0000,
                 sat_gnt[i], sat_det[i], sat_pls[i]);
        end

        // One reset cycle with det=1111: everything drops, and the lowest
        // requester wins.
        do_reset("rst3", 4'b1111, 4'b0001);
        step("post1", 4'b0110, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        step("post2", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_detect_sched.md
RUN_DETECT_SCHED -- requirements
Module: run_detect_sched

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of requesting serial channels (2..8).
REQ-002 The block SHALL have parameter THRESH, default 2, meaning the run length of consecutive 1s at which detection asserts (1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NCH bits: per-channel request, meaning the channel presents a bit.
REQ-006 The block SHALL have port bit_in, input, NCH bits: the per-channel serial data bit, valid while req is high.
REQ-007 The block SHALL have port clr, input, NCH bits: per-channel run-state clear.
REQ-008 The block SHALL have port gnt, output, NCH bits: one-hot combinational grant; the bit is consumed in the cycle req&gnt is high.
REQ-009 The block SHALL have port det, output, NCH bits: registered per-channel Moore detect level.
REQ-010 The block SHALL have port det_pulse, output, NCH bits: registered one-cycle pulse on each det rising edge.

Function
REQ-011 The block SHALL share one run detector among NCH channels, with one saturating run counter per channel (4 bits).
REQ-012 The block SHALL grant at most one channel per cycle, round-robin: the first requesting channel at or after pointer ptr, wrapping NCH-1 -> 0.
REQ-013 gnt SHALL be all-zero when req is all-zero; gnt SHALL never be high for a non-requesting channel.
REQ-014 After a grant to channel k, ptr SHALL become (k+1) mod NCH; with no grant, ptr SHALL hold.
REQ-015 On a consumed bit_in=1, the channel counter SHALL increment, saturating at THRESH.
REQ-016 On a consumed bit_in=0, the channel counter SHALL load 0.
REQ-017 Counters of non-granted channels SHALL hold.
REQ-018 det[k] SHALL equal (counter[k]==THRESH), decoded from registered state only: pure Moore behaviour, 1 cycle latency after the consuming grant.
REQ-019 det_pulse[k] SHALL be high for exactly the one cycle in which det[k] first rises; it SHALL NOT re-pulse while the counter stays saturated.
REQ-020 clr[k] SHALL load counter[k] to 0 at the next edge.
REQ-021 If clr[k] coincides with a grant to k, clr SHALL win and the bit SHALL count as consumed; ptr SHALL still advance.
REQ-022 clr SHALL NOT affect gnt or ptr.
REQ-023 A saturated channel receiving further 1s SHALL keep det high; a single 0 SHALL drop det on the next edge.

Reset
REQ-024 While reset is high at a rising edge: ptr=0, all counters=0, det=0, det_pulse=0.
REQ-025 Reset SHALL override clr and grants in the same cycle, and reset asserted mid-run SHALL discard partial runs.
REQ-026 gnt during reset SHALL still follow REQ-012 with ptr=0, but no bit SHALL be consumed.

Verification
REQ-027 Scenario: NCH=4, THRESH=2, req=4'b0001, bit_in[0]=1 for 3 cycles -> gnt=0001 each cycle; det[0] rises one cycle after the 2nd grant; det_pulse[0] is high for exactly 1 cycle.
REQ-028 Scenario: req=4'b1111 held for 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,... with no skips.
REQ-029 Scenario: req=4'b1010 from ptr=0 -> gnt=0010 then 1000 then 0010; channels 0 and 2 counters unchanged.
REQ-030 Scenario: channel 1 saturated (det[1]=1), then grant with bit_in[1]=0 -> det[1]=0 next cycle; then a 1,1 pattern -> det_pulse[1] fires again.
REQ-031 Scenario: clr[2] together with a grant to 2 and bit_in[2]=1 at counter=1 -> counter=0, det[2]=0, ptr=3.
REQ-032 Scenario: reset asserted for 1 cycle while det=4'b1111 -> next cycle det=0, det_pulse=0, first grant goes to the lowest requesting channel.
